// File: rtl/add_subb_serial_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding and
// the digit-count / counter-width derivations used by the RTL and its bench.
package add_subb_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit carry spans 0..2 because each operand may contribute its own +1.
    localparam int CARRY_W = 2;

    function automatic int digit_count(input int w, input int d);
        return w / d;
    endfunction

    // One spare bit so the counter can step past N-1 without wrapping.
    function automatic int counter_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/add_subb_serial_digit.sv
// Combinational D-bit slice: optionally inverts each operand digit and adds
// them with a 0..2 carry-in, returning the D-bit sum and a 0..2 carry-out.
module add_subb_serial_digit
    import add_subb_serial_pkg::*;
#(
    parameter int D = 4
) (
    input  logic [D-1:0]       a_k,
    input  logic [D-1:0]       b_k,
    input  logic               subb_a,
    input  logic               subb_b,
    input  logic [CARRY_W-1:0] cin,
    output logic [D-1:0]       sum,
    output logic [CARRY_W-1:0] cout
);

    logic [D-1:0]   a_eff;
    logic [D-1:0]   b_eff;
    logic [D+1:0]   total;

    for (genvar gi = 0; gi < D; gi++) begin : g_invert
        assign a_eff[gi] = a_k[gi] ^ subb_a;
        assign b_eff[gi] = b_k[gi] ^ subb_b;
    end

    assign total = (D+2)'(a_eff) + (D+2)'(b_eff) + (D+2)'(cin);
    assign sum   = total[D-1:0];
    assign cout  = total[D+1:D];

endmodule

// File: rtl/add_subb_serial.sv
// Digit-serial two's-complement add/subtract: captures operands, processes one
// D-bit digit per cycle LSB first, then presents s/c until the consumer accepts.
module add_subb_serial
    import add_subb_serial_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         subb_a,
    input  logic         subb_b,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         c
);

    localparam int N  = digit_count(W, D);
    localparam int CW = counter_width(N);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    state_t               state_reg;
    state_t               state_next;
    logic                 in_ready_reg;
    logic                 in_ready_next;
    logic                 out_valid_reg;
    logic                 out_valid_next;

    logic [W-1:0]         a_reg;
    logic [W-1:0]         b_reg;
    logic                 subb_a_reg;
    logic                 subb_b_reg;
    logic [CARRY_W-1:0]   carry_reg;
    logic [CW-1:0]        cnt_reg;
    logic [W-1:0]         res_reg;
    logic [W-1:0]         res_next;
    logic [W-1:0]         s_reg;
    logic                 c_reg;

    logic                 accept;
    logic                 busy;
    logic                 last_digit;
    logic [D-1:0]         digit_sum;
    logic [CARRY_W-1:0]   digit_cout;

    assign accept     = (state_reg == IDLE) && in_valid && in_ready_reg;
    assign busy       = (state_reg == BUSY);
    assign last_digit = busy && (cnt_reg == LAST_DIGIT);

    add_subb_serial_digit #(.D(D)) u_digit (
        .a_k    (a_reg[D-1:0]),
        .b_k    (b_reg[D-1:0]),
        .subb_a (subb_a_reg),
        .subb_b (subb_b_reg),
        .cin    (carry_reg),
        .sum    (digit_sum),
        .cout   (digit_cout)
    );

    // New digit enters at the top; after N shifts digit 0 sits at the LSB.
    assign res_next = W'({digit_sum, res_reg} >> D);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (accept)     state_next = BUSY;
            BUSY:    if (last_digit) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so no input reaches
    // an output combinationally, and in_ready stays low throughout reset.
    always_comb begin
        in_ready_next  = 1'b0;
        out_valid_next = 1'b0;
        unique case (state_next)
            IDLE:    in_ready_next  = 1'b1;
            DONE:    out_valid_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            subb_a_reg <= 1'b0;
            subb_b_reg <= 1'b0;
            carry_reg  <= '0;
            cnt_reg    <= '0;
            res_reg    <= '0;
        end else if (accept) begin
            a_reg      <= a;
            b_reg      <= b;
            subb_a_reg <= subb_a;
            subb_b_reg <= subb_b;
            carry_reg  <= CARRY_W'(subb_a) + CARRY_W'(subb_b);
            cnt_reg    <= '0;
        end else if (busy) begin
            a_reg     <= a_reg >> D;
            b_reg     <= b_reg >> D;
            carry_reg <= digit_cout;
            cnt_reg   <= cnt_reg + CW'(1);
            res_reg   <= res_next;
        end
    end

    // Visible result only moves on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_reg <= '0;
            c_reg <= 1'b0;
        end else if (last_digit) begin
            s_reg <= res_next;
            c_reg <= digit_cout[0];
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign s         = s_reg;
    assign c         = c_reg;

endmodule

// File: tb/tb_add_subb_serial.sv
// Self-checking bench for add_subb_serial: directed table, random W=16 ops,
// backpressure and mid-operation reset sequences, and an exhaustive W=4 sweep.
module tb_add_subb_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid16, in_ready16, subb_a16, subb_b16, out_valid16, out_ready16, c16;
    logic [15:0] a16, b16, s16;
    logic        in_valid4, in_ready4, subb_a4, subb_b4, out_valid4, out_ready4, c4;
    logic [3:0]  a4, b4, s4;

    add_subb_serial #(.W(16), .D(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .subb_a(subb_a16), .subb_b(subb_b16), .a(a16), .b(b16),
        .out_valid(out_valid16), .out_ready(out_ready16), .s(s16), .c(c16)
    );

    add_subb_serial #(.W(4), .D(2)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .subb_a(subb_a4), .subb_b(subb_b4), .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(out_ready4), .s(s4), .c(c4)
    );

    int tests = 0;
    int fails = 0;
    logic [15:0] last_s16;
    logic        last_c16;

    typedef struct {
        logic        sa;
        logic        sb;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_s;
        logic        exp_c;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // T = A' + B' + subb_a + subb_b on plain integers, where ~x on w bits is (2^w-1)-x.
    function automatic longint unsigned ref_t(input int w, input logic sa, input logic sb,
                                              input longint unsigned av, input longint unsigned bv);
        longint unsigned m;
        m = (64'd1 << w) - 64'd1;
        return (sa ? m - av : av) + (sb ? m - bv : bv) + 64'(sa) + 64'(sb);
    endfunction

    // Run one W=16 operation; records latency and the presented result.
    task automatic op16(input logic sa, input logic sb, input logic [15:0] av, input logic [15:0] bv,
                        input int hold, output logic [15:0] got_s, output logic got_c, output int lat);
        int guard;
        guard = 0;
        while (!in_ready16 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        in_valid16 = 1'b1; subb_a16 = sa; subb_b16 = sb; a16 = av; b16 = bv;
        @(negedge clk);
        in_valid16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        subb_a16 = 1'($urandom); subb_b16 = 1'($urandom);
        check("s_hold_busy", {15'd0, c16, s16}, {15'd0, last_c16, last_s16});
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid16 && lat < 20);
        got_s = s16;
        got_c = c16;
        repeat (hold) @(negedge clk);
        out_ready16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready16 = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        logic [15:0] gs;
        logic        gc;
        int          lat;
        longint unsigned t;
        logic [15:0] exp_s;
        logic        exp_c;
        int          bad_stable;
        int          ov_seen;

        vecs[0] = '{1'b0, 1'b0, 16'h0003, 16'h0005, 16'h0008, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 16'h0005, 16'h0003, 16'hFFFE, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'h0001, 16'h0001, 16'hFFFE, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1};

        rst = 1'b0;
        in_valid16 = 0; subb_a16 = 0; subb_b16 = 0; a16 = 0; b16 = 0; out_ready16 = 0;
        in_valid4 = 0; subb_a4 = 0; subb_b4 = 0; a4 = 0; b4 = 0; out_ready4 = 0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready16}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid16}, 32'd0);
        check("rst_s", {16'd0, s16}, 32'd0);
        check("rst_c", {31'd0, c16}, 32'd0);
        rst = 1'b1;
        #1 check("rel_in_ready_before_edge", {31'd0, in_ready16}, 32'd0);
        @(negedge clk);
        check("rel_in_ready_after_edge", {31'd0, in_ready16}, 32'd1);
        last_s16 = 16'd0;
        last_c16 = 1'b0;

        for (int i = 0; i < 8; i++) begin
            op16(vecs[i].sa, vecs[i].sb, vecs[i].a, vecs[i].b, i % 3, gs, gc, lat);
            check($sformatf("vec%0d_s", i), {16'd0, gs}, {16'd0, vecs[i].exp_s});
            check($sformatf("vec%0d_c", i), {31'd0, gc}, {31'd0, vecs[i].exp_c});
            check($sformatf("vec%0d_latency", i), lat, 4);
            last_s16 = vecs[i].exp_s;
            last_c16 = vecs[i].exp_c;
        end

        for (int i = 0; i < 40; i++) begin
            logic        sa, sb;
            logic [15:0] av, bv;
            sa = 1'($urandom); sb = 1'($urandom);
            av = 16'($urandom); bv = 16'($urandom);
            t = ref_t(16, sa, sb, av, bv);
            exp_s = t[15:0];
            exp_c = t[16];
            op16(sa, sb, av, bv, $urandom_range(0, 3), gs, gc, lat);
            check($sformatf("rand%0d_sc", i), {15'd0, gc, gs}, {15'd0, exp_c, exp_s});
            check($sformatf("rand%0d_latency", i), lat, 4);
            last_s16 = exp_s;
            last_c16 = exp_c;
        end

        // Backpressure: hold DONE for five cycles while in_valid pulses.
        t = ref_t(16, 1'b0, 1'b0, 64'h1234, 64'h0FF1);
        in_valid16 = 1'b1; subb_a16 = 0; subb_b16 = 0; a16 = 16'h1234; b16 = 16'h0FF1;
        @(negedge clk);
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", lat, 4);
        for (int k = 0; k < 5; k++) begin
            in_valid16 = ~in_valid16;
            a16 = 16'($urandom); b16 = 16'($urandom);
            @(negedge clk);
            check($sformatf("bp%0d_state", k), {13'd0, out_valid16, in_ready16, c16, s16},
                  {13'd0, 1'b1, 1'b0, t[16], t[15:0]});
        end
        in_valid16 = 1'b0;
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        check("bp_release", {30'd0, out_valid16, in_ready16}, 32'd1);
        check("bp_idle_hold", {15'd0, c16, s16}, {15'd0, t[16], t[15:0]});
        @(negedge clk);
        check("bp_no_extra_op", {30'd0, out_valid16, in_ready16}, 32'd1);

        // Reset for one cycle in the middle of BUSY.
        in_valid16 = 1'b1; subb_a16 = 0; subb_b16 = 1; a16 = 16'h0007; b16 = 16'h0009;
        @(negedge clk);
        in_valid16 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 check("mid_rst_outputs", {13'd0, out_valid16, in_ready16, c16, s16}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("mid_rst_ready_held", {31'd0, in_ready16}, 32'd0);
        @(negedge clk);
        check("mid_rst_ready_back", {31'd0, in_ready16}, 32'd1);
        ov_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid16) ov_seen++;
        end
        check("mid_rst_no_result", ov_seen, 0);
        last_s16 = 16'd0;
        last_c16 = 1'b0;
        op16(1'b1, 1'b0, 16'h0010, 16'h0004, 0, gs, gc, lat);
        t = ref_t(16, 1'b1, 1'b0, 64'h0010, 64'h0004);
        check("post_rst_sc", {15'd0, gc, gs}, {15'd0, t[16], t[15:0]});
        check("post_rst_latency", lat, 4);

        // Exhaustive W=4, D=2 sweep with random consumer stalls.
        bad_stable = 0;
        for (int sa = 0; sa < 2; sa++)
        for (int sb = 0; sb < 2; sb++)
        for (int av = 0; av < 16; av++)
        for (int bv = 0; bv < 16; bv++) begin
            int guard, stalls;
            logic r;
            logic [4:0] got;
            t = ref_t(4, 1'(sa), 1'(sb), 64'(av), 64'(bv));
            guard = 0;
            while (!in_ready4 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            in_valid4 = 1'b1; subb_a4 = 1'(sa); subb_b4 = 1'(sb); a4 = 4'(av); b4 = 4'(bv);
            @(negedge clk);
            in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
            lat = 0;
            do begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end while (!out_valid4 && lat < 20);
            got = {c4, s4};
            check($sformatf("ex4_sa%0d_sb%0d_a%0h_b%0h", sa, sb, av, bv),
                  {27'd0, got}, {27'd0, t[4], t[3:0]});
            if (lat != 2) check("ex4_latency", lat, 2);
            stalls = 0;
            do begin
                r = 1'($urandom_range(0, 1));
                out_ready4 = r;
                @(posedge clk);
                @(negedge clk);
                stalls++;
                if (!r && (!out_valid4 || {c4, s4} != got)) bad_stable++;
            end while (!r && stalls < 50);
            out_ready4 = 1'b0;
        end
        check("ex4_stall_stability", bad_stable, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
